// File: rtl/seq_multiplier_if.sv
// Handshake bundle for seq_multiplier: operand request side (a/b/signed,
// valid_in/ready_out) and result side (c_out, valid_out/ready_in) plus the
// busy indicator. The multiplier connects through the slave modport; the
// requester/consumer uses the master modport.
interface seq_multiplier_if #(
  parameter int WIDTH = 256
);
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic               signed_in;
  logic               valid_in;
  logic               ready_out;
  logic [2*WIDTH-1:0] c_out;
  logic               valid_out;
  logic               ready_in;
  logic               busy_out;

  modport master (
    output a_in, b_in, signed_in, valid_in, ready_in,
    input  ready_out, c_out, valid_out, busy_out
  );

  modport slave (
    input  a_in, b_in, signed_in, valid_in, ready_in,
    output ready_out, c_out, valid_out, busy_out
  );
endinterface

// File: rtl/seq_multiplier.sv
// seq_multiplier: sequential shift-add multiplier retiring DIGIT_BITS
// multiplier bits per cycle (N = WIDTH/DIGIT_BITS compute cycles, constant
// latency). Operands are captured at the input handshake; the product is held
// on c_out until the consumer accepts it.
// Optional feature macro: SEQMUL_SIGNED_EN -- adds two's-complement operands
// (magnitude multiply plus a FIXUP negation state that is always traversed).
module seq_multiplier #(
  parameter int WIDTH      = 256,
  parameter int DIGIT_BITS = 4
) (
  input logic           clk_in,
  input logic           rst_n_in,
  seq_multiplier_if.slave mul_bus
);

  localparam int N  = WIDTH / DIGIT_BITS;
  localparam int CW = $clog2(N) + 1;
  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);

  generate
    if ((WIDTH % DIGIT_BITS) != 0) begin : g_bad_digit_bits
      $error("seq_multiplier: WIDTH must be a multiple of DIGIT_BITS");
    end
  endgenerate

`ifdef SEQMUL_SIGNED_EN
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COMPUTING = 2'd1,
    ST_FIXUP     = 2'd2,
    ST_DONE      = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COMPUTING = 2'd1,
    ST_DONE      = 2'd3
  } state_t;
`endif

`ifdef SEQMUL_SIGNED_EN
  // Absolute value of a two's-complement operand; the most negative value
  // maps onto its (representable) unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    magnitude = v[WIDTH-1] ? (~v + WIDTH'(1'b1)) : v;
  endfunction
`endif

  state_t            state_r;
  state_t            state_s;
  // Multiplicand is kept pre-shifted: shifting it left by one digit each
  // cycle is equivalent to weighting digit k by 2^(k*DIGIT_BITS).
  logic [PW-1:0]     a_r;
  logic [WIDTH-1:0]  b_r;
  logic [PW-1:0]     acc_r;
  logic [CW-1:0]     count_r;
  logic              neg_r;
  logic              ready_r;
  logic              valid_r;
  logic              busy_r;
  logic [PW-1:0]     c_r;

  logic                  hs_s;
  logic                  retire_s;
  logic                  last_digit_s;
  logic [DIGIT_BITS-1:0] digit_s;
  logic [PW-1:0]         pp_s;
  logic [PW-1:0]         acc_sum_s;
  logic [PW-1:0]         result_s;

  assign mul_bus.ready_out = ready_r;
  assign mul_bus.valid_out = valid_r;
  assign mul_bus.busy_out  = busy_r;
  assign mul_bus.c_out     = c_r;

  // Handshake qualifiers and the per-digit partial product / accumulation.
  always_comb begin
    hs_s         = mul_bus.valid_in & ready_r;
    retire_s     = valid_r & mul_bus.ready_in;
    last_digit_s = (count_r == LAST_DIGIT);
    digit_s      = b_r[DIGIT_BITS-1:0];
    pp_s         = a_r * {{(PW-DIGIT_BITS){1'b0}}, digit_s};
    acc_sum_s    = acc_r + pp_s;
`ifdef SEQMUL_SIGNED_EN
    result_s     = neg_r ? (-acc_r) : acc_r;
`else
    result_s     = acc_sum_s;
`endif
  end

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic; no early exit, every digit costs one cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (hs_s) begin
          state_s = ST_COMPUTING;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_COMPUTING: begin
        if (last_digit_s) begin
`ifdef SEQMUL_SIGNED_EN
          state_s = ST_FIXUP;
`else
          state_s = ST_DONE;
`endif
        end else begin
          state_s = ST_COMPUTING;
        end
      end
`ifdef SEQMUL_SIGNED_EN
      ST_FIXUP: begin
        state_s = ST_DONE;
      end
`endif
      ST_DONE: begin
        if (retire_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Operand capture, digit-serial accumulation and sign fix-up.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      a_r     <= {PW{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      acc_r   <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
      neg_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (hs_s) begin
`ifdef SEQMUL_SIGNED_EN
            if (mul_bus.signed_in) begin
              a_r   <= {{WIDTH{1'b0}}, magnitude(mul_bus.a_in)};
              b_r   <= magnitude(mul_bus.b_in);
              neg_r <= mul_bus.a_in[WIDTH-1] ^ mul_bus.b_in[WIDTH-1];
            end else begin
              a_r   <= {{WIDTH{1'b0}}, mul_bus.a_in};
              b_r   <= mul_bus.b_in;
              neg_r <= 1'b0;
            end
`else
            a_r   <= {{WIDTH{1'b0}}, mul_bus.a_in};
            b_r   <= mul_bus.b_in;
            neg_r <= 1'b0;
`endif
            acc_r   <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
          end
        end
        ST_COMPUTING: begin
          acc_r   <= acc_sum_s;
          a_r     <= a_r << DIGIT_BITS;
          b_r     <= b_r >> DIGIT_BITS;
          count_r <= count_r + CW'(1'b1);
        end
`ifdef SEQMUL_SIGNED_EN
        ST_FIXUP: begin
          acc_r <= result_s;
        end
`endif
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

  // Registered outputs, derived from the state being entered.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ready_r <= 1'b1;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      c_r     <= {PW{1'b0}};
    end else begin
      ready_r <= (state_s == ST_IDLE);
      busy_r  <= (state_s != ST_IDLE);
      valid_r <= (state_s == ST_DONE);
      if ((state_r != ST_DONE) && (state_s == ST_DONE)) begin
        c_r <= result_s;
      end
    end
  end

endmodule
